hazard_scoreboard: RTL and testbench
====================================

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, with ports as follows.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
REQ-002 The instruction and destination inputs SHALL be:
- id_ir  in  32  instruction in decode.
- id_valid  in  1  id_ir holds a real instruction.
- dst_ws  in  5  destination register of id_ir, from the destination decoder.
- dst_we  in  1  id_ir writes dst_ws.
- flush  in  1  kill the decode instruction (taken branch or jump).
REQ-003 The outputs SHALL be:
- stall  out  1  hold IF/ID and inject a bubble into EX.
- fwd_a  out  2  rs operand source.
- fwd_b  out  2  rt operand source.
- Source encoding for fwd_a/fwd_b: 00 regfile, 01 EX, 10 MEM, 11 WB.
- stall_cnt  out  16  saturating count of stall cycles.

Function
REQ-004 The block SHALL track three registered slots (EX, MEM, WB); each slot holds {valid, ws[4:0], we, is_load}.
REQ-005 is_load SHALL be 1 iff id_ir[31:26]==6'b100011.
REQ-006 Source use SHALL be decoded as follows:
- rs = id_ir[25:21] is used unless the opcode is 000010 or 000011.
- rt = id_ir[20:16] is used for opcodes 000000, 000100, 000101 and 101011.
REQ-007 A slot SHALL match a source iff:
- the slot is valid,
- its we is 1,
- its ws is nonzero,
- its ws equals that source,
- id_valid is 1.
REQ-008 stall SHALL be combinational and SHALL equal 1 iff the EX slot is_load is 1 and the EX slot matches a used source, all with flush equal to 0.
REQ-009 On each rising edge with stall=0, the slots SHALL shift as follows:
- WB<=MEM.
- MEM<=EX.
- EX<={id_valid&~flush, dst_ws, dst_we, is_load}.
REQ-010 On each rising edge with stall=1, WB<=MEM and MEM<=EX SHALL still occur, and EX SHALL become invalid (bubble).
REQ-011 When flush=1, the block SHALL force stall=0 and load an invalid EX slot, regardless of hazards (flush wins over stall).
REQ-012 fwd_a and fwd_b SHALL be combinational, with priority EX (01) > MEM (10) > WB (11) > regfile (00).
REQ-013 A load in EX SHALL never be selected as a forward source, because it stalls instead per REQ-008.
REQ-014 An unused source, or register 0, SHALL yield fwd code 00.
REQ-015 stall_cnt SHALL increment by 1 on every rising edge where stall=1, and SHALL saturate at 16'hFFFF.
REQ-016 Latency SHALL be 0 cycles from id_ir to stall/fwd, and 1 cycle from id_ir to EX slot occupancy.

Reset
REQ-017 While rst=1 at a rising edge, the block SHALL:
- clear all slot valid bits,
- clear stall_cnt to 0.
REQ-018 After reset, with the slots empty, the block SHALL output stall=0, fwd_a=00 and fwd_b=00.
REQ-019 A reset asserted mid-stall SHALL discard all pending slots, and no stall SHALL persist past the reset edge.

Configuration
REQ-020 The macro HAZ_FWD_EN SHALL select forwarding.
- Defined: behaviour SHALL be as REQ-008 and REQ-012.
- Undefined: fwd_a and fwd_b SHALL be tied to 00.
- Undefined: stall SHALL be 1 iff the EX slot or MEM slot matches a used source, with any is_load value.
- Undefined: a WB match SHALL NOT stall; it is resolved by the write-first register file.

Verification
REQ-021 The bench SHALL cover the following directed scenarios:
- addi $3 in EX, then add $4,$3,$5 in ID -> stall=0, fwd_a=01, fwd_b=00.
- lw $2 in EX, then add $6,$2,$2 in ID -> stall=1 for one cycle, then fwd_a=fwd_b=10, and stall_cnt=1.
- lw $2 in EX with flush=1 on the dependent instruction -> stall=0, and EX holds a bubble next cycle.
- $7 written by EX and MEM, and WB writes $7 -> fwd_a=01 (EX priority).
- Destination $0 in every slot, then add $1,$0,$0 -> stall=0, fwd=00.
- HAZ_FWD_EN undefined, addi $3 then add $4,$3,$3 -> stall=1 for two cycles, then fwd=00.

Source files
------------

// File: rtl/hazard_scoreboard.sv
// Decode-stage hazard scoreboard: tracks EX/MEM/WB destinations, drives stall and operand forwarding.
// Define HAZ_FWD_EN to enable forwarding; otherwise any EX/MEM dependency stalls and fwd_a/fwd_b stay 00.
module hazard_scoreboard (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] id_ir,
  input  logic        id_valid,
  input  logic [4:0]  dst_ws,
  input  logic        dst_we,
  input  logic        flush,
  output logic        stall,
  output logic [1:0]  fwd_a,
  output logic [1:0]  fwd_b,
  output logic [15:0] stall_cnt
);

  typedef struct packed {
    logic       valid;
    logic [4:0] ws;
    logic       we;
    logic       ld;
  } slot_t;

  slot_t ex_s, mem_s, wb_s;

  logic [5:0] opcode;
  logic [4:0] rs, rt;
  logic       rs_used, rt_used, is_load;

  assign opcode  = id_ir[31:26];
  assign rs      = id_ir[25:21];
  assign rt      = id_ir[20:16];
  assign is_load = (opcode == 6'b100011);
  assign rs_used = (opcode != 6'b000010) && (opcode != 6'b000011);
  assign rt_used = (opcode == 6'b000000) || (opcode == 6'b000100) ||
                   (opcode == 6'b000101) || (opcode == 6'b101011);

  function automatic logic hit(input slot_t s, input logic [4:0] src);
    return s.valid & s.we & (s.ws != '0) & (s.ws == src) & id_valid;
  endfunction

  function automatic logic [1:0] src_sel(input logic e, input logic m, input logic w);
    if (e)      return 2'b01;
    else if (m) return 2'b10;
    else if (w) return 2'b11;
    else        return 2'b00;
  endfunction

  logic ex_rs, ex_rt, mem_rs, mem_rt, wb_rs, wb_rt;

  assign ex_rs  = hit(ex_s,  rs) & rs_used;
  assign ex_rt  = hit(ex_s,  rt) & rt_used;
  assign mem_rs = hit(mem_s, rs) & rs_used;
  assign mem_rt = hit(mem_s, rt) & rt_used;
  assign wb_rs  = hit(wb_s,  rs) & rs_used;
  assign wb_rt  = hit(wb_s,  rt) & rt_used;

  always_comb begin
    stall = 1'b0;
    fwd_a = 2'b00;
    fwd_b = 2'b00;
`ifdef HAZ_FWD_EN
    // A load in EX has no data yet: it stalls and is never a forward source.
    stall = ~flush & ex_s.ld & (ex_rs | ex_rt);
    fwd_a = src_sel(ex_rs & ~ex_s.ld, mem_rs, wb_rs);
    fwd_b = src_sel(ex_rt & ~ex_s.ld, mem_rt, wb_rt);
`else
    // WB hits are covered by the write-first register file.
    stall = ~flush & (ex_rs | ex_rt | mem_rs | mem_rt);
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_s  <= '0;
      mem_s <= '0;
      wb_s  <= '0;
    end else begin
      wb_s  <= mem_s;
      mem_s <= ex_s;
      if (stall) ex_s <= '0;
      else       ex_s <= '{valid: id_valid & ~flush, ws: dst_ws, we: dst_we, ld: is_load};
    end
  end

  always_ff @(posedge clk) begin
    if (rst)                         stall_cnt <= '0;
    else if (stall && stall_cnt != '1) stall_cnt <= stall_cnt + 16'd1;
  end

  logic unused_bits;
  assign unused_bits = ^{id_ir[15:0], mem_s.ld, wb_s, wb_rs, wb_rt, ex_s.ld};

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard with a stage-array reference model; honours HAZ_FWD_EN like the design.
module tb_hazard_scoreboard;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] id_ir = '0;
  logic        id_valid = 1'b0;
  logic [4:0]  dst_ws = '0;
  logic        dst_we = 1'b0;
  logic        flush = 1'b0;
  logic        stall;
  logic [1:0]  fwd_a, fwd_b;
  logic [15:0] stall_cnt;

  int checks = 0;
  int errors = 0;
  logic chk_en = 1'b0;

  hazard_scoreboard dut (
    .clk(clk), .rst(rst), .id_ir(id_ir), .id_valid(id_valid), .dst_ws(dst_ws),
    .dst_we(dst_we), .flush(flush), .stall(stall), .fwd_a(fwd_a), .fwd_b(fwd_b),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  // Model pipeline: index 0 = EX, 1 = MEM, 2 = WB.
  logic       m_v  [3] = '{1'b0, 1'b0, 1'b0};
  logic [4:0] m_ws [3] = '{5'd0, 5'd0, 5'd0};
  logic       m_we [3] = '{1'b0, 1'b0, 1'b0};
  logic       m_ld [3] = '{1'b0, 1'b0, 1'b0};
  int         m_cnt = 0;

  function automatic void m_eval(output logic st, output logic [1:0] fa, output logic [1:0] fb);
    logic [5:0] op;
    logic [4:0] src [2];
    logic       used [2];
    logic [1:0] code [2];
    op      = id_ir[31:26];
    src[0]  = id_ir[25:21];
    src[1]  = id_ir[20:16];
    used[0] = !(op == 6'd2 || op == 6'd3);
    used[1] = (op == 6'd0 || op == 6'd4 || op == 6'd5 || op == 6'd43);
    st = 1'b0;
    for (int k = 0; k < 2; k++) begin
      code[k] = 2'b00;
      for (int i = 0; i < 3; i++) begin
        if (used[k] && id_valid && m_v[i] && m_we[i] && m_ws[i] != 0 && m_ws[i] == src[k]) begin
`ifdef HAZ_FWD_EN
          if (i == 0 && m_ld[0]) st = 1'b1;
          else if (code[k] == 2'b00) code[k] = 2'(i + 1);
`else
          if (i < 2) st = 1'b1;
`endif
        end
      end
    end
    if (flush) st = 1'b0;
`ifdef HAZ_FWD_EN
    fa = code[0];
    fb = code[1];
`else
    fa = 2'b00;
    fb = 2'b00;
`endif
  endfunction

  always @(posedge clk) begin
    logic       st;
    logic [1:0] a, b;
    if (rst) begin
      m_v[0] <= 1'b0; m_v[1] <= 1'b0; m_v[2] <= 1'b0;
      m_cnt  <= 0;
    end else begin
      m_eval(st, a, b);
      if (st && m_cnt < 65535) m_cnt <= m_cnt + 1;
      m_v[2] <= m_v[1];  m_ws[2] <= m_ws[1]; m_we[2] <= m_we[1]; m_ld[2] <= m_ld[1];
      m_v[1] <= m_v[0];  m_ws[1] <= m_ws[0]; m_we[1] <= m_we[0]; m_ld[1] <= m_ld[0];
      m_v[0]  <= st ? 1'b0 : (id_valid && !flush);
      m_ws[0] <= dst_ws;
      m_we[0] <= dst_we;
      m_ld[0] <= (id_ir[31:26] == 6'h23);
    end
  end

  always @(negedge clk) begin
    logic       st;
    logic [1:0] a, b;
    if (chk_en) begin
      m_eval(st, a, b);
      checks += 4;
      if (stall !== st) begin errors++; $display("FAIL model_stall t=%0t got %b expected %b", $time, stall, st); end
      if (fwd_a !== a) begin errors++; $display("FAIL model_fwd_a t=%0t got %b expected %b", $time, fwd_a, a); end
      if (fwd_b !== b) begin errors++; $display("FAIL model_fwd_b t=%0t got %b expected %b", $time, fwd_b, b); end
      if (stall_cnt !== 16'(m_cnt)) begin
        errors++; $display("FAIL model_stall_cnt t=%0t got %0d expected %0d", $time, stall_cnt, m_cnt);
      end
    end
  end

  function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
    return {6'd0, rs, rt, rd, 5'd0, 6'h20};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt);
    return {op, rs, rt, 16'd4};
  endfunction

  task automatic issue(input logic [31:0] ir, input logic [4:0] ws, input logic we, input logic fl = 1'b0);
    @(posedge clk); #1;
    id_ir = ir; id_valid = 1'b1; dst_ws = ws; dst_we = we; flush = fl;
    @(negedge clk); #1;
  endtask

  task automatic idle(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      id_valid = 1'b0; dst_we = 1'b0; flush = 1'b0; id_ir = '0; dst_ws = '0;
      @(negedge clk); #1;
    end
  endtask

  // Hold the decode instruction while the model says it must stall, with a cycle budget.
  task automatic hold();
    logic       st;
    logic [1:0] a, b;
    for (int i = 0; i < 6; i++) begin
      m_eval(st, a, b);
      if (!st) return;
      @(posedge clk); #1;
      @(negedge clk); #1;
    end
    checks++; errors++;
    $display("FAIL hold_timeout stall still %b after 6 cycles", stall);
  endtask

  task automatic lit(input string nm, input logic est, input logic [1:0] ea, input logic [1:0] eb);
    checks += 3;
    if (stall !== est) begin errors++; $display("FAIL %s stall got %b expected %b", nm, stall, est); end
    if (fwd_a !== ea)  begin errors++; $display("FAIL %s fwd_a got %b expected %b", nm, fwd_a, ea); end
    if (fwd_b !== eb)  begin errors++; $display("FAIL %s fwd_b got %b expected %b", nm, fwd_b, eb); end
  endtask

  task automatic lit_cnt(input string nm, input int exp);
    checks++;
    if (stall_cnt !== 16'(exp)) begin
      errors++; $display("FAIL %s stall_cnt got %0d expected %0d", nm, stall_cnt, exp);
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    rst = 1'b0;
    chk_en = 1'b1;
    lit("reset", 1'b0, 2'b00, 2'b00);
    lit_cnt("reset", 0);

    // addi $3 then add $4,$3,$5
    idle(1);
    issue(itype(6'h08, 5'd0, 5'd3), 5'd3, 1'b1);
    issue(rtype(5'd3, 5'd5, 5'd4), 5'd4, 1'b1);
`ifdef HAZ_FWD_EN
    lit("alu_fwd", 1'b0, 2'b01, 2'b00);
    hold();
    lit_cnt("alu_fwd", 0);
`else
    lit("alu_dep", 1'b1, 2'b00, 2'b00);
    hold();
    lit("alu_dep_after", 1'b0, 2'b00, 2'b00);
    lit_cnt("alu_dep", 2);
`endif

    // lw $2 then add $6,$2,$2
    idle(3);
    issue(itype(6'h23, 5'd1, 5'd2), 5'd2, 1'b1);
    issue(rtype(5'd2, 5'd2, 5'd6), 5'd6, 1'b1);
    lit("load_use", 1'b1, 2'b00, 2'b00);
    hold();
`ifdef HAZ_FWD_EN
    lit("load_use_after", 1'b0, 2'b10, 2'b10);
    lit_cnt("load_use", 1);
`else
    lit("load_use_after", 1'b0, 2'b00, 2'b00);
    lit_cnt("load_use", 4);
`endif

    // lw $2 then flushed dependent; the flushed add must not occupy EX
    idle(3);
    issue(itype(6'h23, 5'd1, 5'd2), 5'd2, 1'b1);
    issue(rtype(5'd2, 5'd2, 5'd6), 5'd6, 1'b1, 1'b1);
    lit("flush", 1'b0, 2'b00, 2'b00);
    issue(rtype(5'd6, 5'd0, 5'd8), 5'd8, 1'b1);
    lit("flush_bubble", 1'b0, 2'b00, 2'b00);

    // $7 written in EX, MEM and WB
    idle(3);
    repeat (3) issue(itype(6'h08, 5'd0, 5'd7), 5'd7, 1'b1);
    issue(rtype(5'd7, 5'd0, 5'd9), 5'd9, 1'b1);
`ifdef HAZ_FWD_EN
    lit("ex_priority", 1'b0, 2'b01, 2'b00);
`else
    lit("ex_priority", 1'b1, 2'b00, 2'b00);
`endif
    hold();
    issue(itype(6'h08, 5'd0, 5'd7), 5'd7, 1'b1);
    issue(itype(6'h08, 5'd0, 5'd7), 5'd7, 1'b1);
    idle(1);
    issue(rtype(5'd7, 5'd0, 5'd9), 5'd9, 1'b1);
`ifdef HAZ_FWD_EN
    lit("mem_priority", 1'b0, 2'b10, 2'b00);
`else
    lit("mem_priority", 1'b1, 2'b00, 2'b00);
`endif
    hold();

    // Destination $0 everywhere
    idle(3);
    repeat (3) issue(itype(6'h08, 5'd0, 5'd0), 5'd0, 1'b1);
    issue(rtype(5'd0, 5'd0, 5'd1), 5'd1, 1'b1);
    lit("reg0", 1'b0, 2'b00, 2'b00);

    // Jump ignores rs; store uses rt
    idle(3);
    issue(itype(6'h23, 5'd0, 5'd5), 5'd5, 1'b1);
    issue({6'b000010, 5'd5, 21'd0}, 5'd0, 1'b0);
    lit("jump_no_rs", 1'b0, 2'b00, 2'b00);
    issue(itype(6'h2b, 5'd1, 5'd5), 5'd0, 1'b0);
`ifdef HAZ_FWD_EN
    lit("store_rt", 1'b0, 2'b00, 2'b10);
    hold();
    lit_cnt("store_rt", 1);
`else
    lit("store_rt", 1'b1, 2'b00, 2'b00);
    hold();
    lit_cnt("store_rt", 8);
`endif

    // Reset asserted while a load-use stall is pending
    idle(3);
    issue(itype(6'h23, 5'd1, 5'd2), 5'd2, 1'b1);
    issue(rtype(5'd2, 5'd2, 5'd6), 5'd6, 1'b1);
    lit("pre_reset_stall", 1'b1, 2'b00, 2'b00);
    rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk); #1;
    lit("mid_stall_reset", 1'b0, 2'b00, 2'b00);
    lit_cnt("mid_stall_reset", 0);
    rst = 1'b0;
    idle(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout reached at %0t", $time);
    $fatal(1, "timeout");
  end

endmodule
